// File: rtl/vend_pkg.sv
// Shared definitions for the vending controller: FSM state type, button
// indices, coin values, credit width and the product-select LED decode.
package vend_pkg;

  localparam int unsigned CREDIT_W = 4;

  // Bit positions within the raw btn bus.
  localparam int unsigned BTN_COIN1  = 0;
  localparam int unsigned BTN_COIN2  = 1;
  localparam int unsigned BTN_VEND   = 2;
  localparam int unsigned BTN_CANCEL = 3;

  localparam logic [CREDIT_W-1:0] COIN1_VAL = 4'd1;
  localparam logic [CREDIT_W-1:0] COIN2_VAL = 4'd2;

  typedef enum logic [1:0] {
    StIdle,
    StCollect,
    StDispense,
    StRefund
  } state_e;

  // Two-bit product select to one-hot LED pattern.
  function automatic logic [3:0] sel_onehot(input logic [1:0] sel);
    return 4'b0001 << sel;
  endfunction

endpackage

// File: rtl/vend_ctrl_fsm_if.sv
// Board-side signal bundle of the vending controller.
//   sw, btn        : switch bank and raw push-buttons (board -> controller)
//   led            : status LEDs
//   dispense       : high while product is being dispensed
//   refund_valid   : one-cycle pulse, refund_amt valid
//   refund_amt     : credit units returned
//   coin_reject    : one-cycle pulse, coin refused (credit ceiling)
//   short_credit   : one-cycle pulse, vend refused (credit below price)
// master = board/stimulus side, slave = controller.
interface vend_ctrl_fsm_if;
  import vend_pkg::*;

  logic [1:0]          sw;
  logic [3:0]          btn;
  logic [3:0]          led;
  logic                dispense;
  logic                refund_valid;
  logic [CREDIT_W-1:0] refund_amt;
  logic                coin_reject;
  logic                short_credit;

  modport master (
    output sw, btn,
    input  led, dispense, refund_valid, refund_amt, coin_reject, short_credit
  );

  modport slave (
    input  sw, btn,
    output led, dispense, refund_valid, refund_amt, coin_reject, short_credit
  );

endinterface

// File: rtl/btn_debounce.sv
// Conditions one raw button bit: 2-flop synchroniser, debounce counter and
// rising-edge detect on the debounced level.
//   clk, rst_n : clock, asynchronous active-low reset
//   btn        : raw asynchronous button level
//   pulse      : one-cycle event on each accepted press
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1250000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic pulse
);

  localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  logic            sync1_q, sync2_q;
  logic            level_q, level_prev_q;
  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      level_q      <= 1'b0;
      level_prev_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      sync1_q      <= btn;
      sync2_q      <= sync1_q;
      level_prev_q <= level_q;
      // Count consecutive cycles that disagree with the accepted level; any
      // agreeing cycle restarts the count.
      if (sync2_q != level_q) begin
        if (cnt_q == CntLast) begin
          level_q <= sync2_q;
          cnt_q   <= '0;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

  assign pulse = level_q & ~level_prev_q;

endmodule

// File: rtl/vend_ctrl_fsm.sv
// Vending-machine controller: debounced coin/vend/cancel events drive a
// credit-accumulating FSM that sequences dispense and refund and drives the
// four user LEDs. All outputs are registered.
//   clk, rst_n : 125 MHz clock, asynchronous active-low reset
//   bus        : board I/O bundle (slave side), see vend_ctrl_fsm_if
module vend_ctrl_fsm
  import vend_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1250000,
  parameter int unsigned DISPENSE_CYCLES = 62500000,
  parameter int unsigned PRICE0          = 2,
  parameter int unsigned PRICE1          = 3,
  parameter int unsigned PRICE2          = 4,
  parameter int unsigned PRICE3          = 5,
  parameter int unsigned MAX_CREDIT      = 15
) (
  input  logic            clk,
  input  logic            rst_n,
  vend_ctrl_fsm_if.slave  bus
);

  localparam int unsigned DispW = (DISPENSE_CYCLES > 1) ? $clog2(DISPENSE_CYCLES) : 1;

  logic [3:0] evt;

  for (genvar i = 0; i < 4; i++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk  (clk),
      .rst_n(rst_n),
      .btn  (bus.btn[i]),
      .pulse(evt[i])
    );
  end

  state_e              state_q;
  logic [CREDIT_W-1:0] credit_q;
  logic [1:0]          sel_q;
  logic [DispW-1:0]    disp_cnt_q;
  logic [3:0]          led_q;
  logic                dispense_q, refund_valid_q, coin_reject_q, short_credit_q;
  logic [CREDIT_W-1:0] refund_amt_q;

  logic [CREDIT_W-1:0] price;
  logic [CREDIT_W-1:0] coin_val;
  logic [CREDIT_W:0]   coin_sum;

  always_comb begin
    unique case (bus.sw)
      2'd0:    price = CREDIT_W'(PRICE0);
      2'd1:    price = CREDIT_W'(PRICE1);
      2'd2:    price = CREDIT_W'(PRICE2);
      default: price = CREDIT_W'(PRICE3);
    endcase
  end

  // coin2 outranks coin1 when both fire together.
  assign coin_val = evt[BTN_COIN2] ? COIN2_VAL : COIN1_VAL;
  // One extra bit so an over-ceiling sum is visible instead of wrapping.
  assign coin_sum = {1'b0, credit_q} + {1'b0, coin_val};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      credit_q       <= '0;
      sel_q          <= '0;
      disp_cnt_q     <= '0;
      led_q          <= '0;
      dispense_q     <= 1'b0;
      refund_valid_q <= 1'b0;
      refund_amt_q   <= '0;
      coin_reject_q  <= 1'b0;
      short_credit_q <= 1'b0;
    end else begin
      refund_valid_q <= 1'b0;
      coin_reject_q  <= 1'b0;
      short_credit_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          led_q <= sel_onehot(bus.sw);
          if (!evt[BTN_CANCEL]) begin
            if (evt[BTN_VEND]) begin
              short_credit_q <= 1'b1;
            end else if (evt[BTN_COIN2] || evt[BTN_COIN1]) begin
              credit_q <= coin_val;
              led_q    <= coin_val;
              state_q  <= StCollect;
            end
          end
        end
        StCollect: begin
          led_q <= credit_q;
          if (evt[BTN_CANCEL]) begin
            state_q        <= StRefund;
            refund_valid_q <= 1'b1;
            refund_amt_q   <= credit_q;
            led_q          <= 4'hf;
          end else if (evt[BTN_VEND]) begin
            sel_q <= bus.sw;
            if (credit_q >= price) begin
              credit_q   <= credit_q - price;
              state_q    <= StDispense;
              dispense_q <= 1'b1;
              disp_cnt_q <= DispW'(DISPENSE_CYCLES - 1);
              led_q      <= sel_onehot(bus.sw);
            end else begin
              short_credit_q <= 1'b1;
            end
          end else if (evt[BTN_COIN2] || evt[BTN_COIN1]) begin
            if (coin_sum > (CREDIT_W + 1)'(MAX_CREDIT)) begin
              coin_reject_q <= 1'b1;
            end else begin
              credit_q <= coin_sum[CREDIT_W-1:0];
              led_q    <= coin_sum[CREDIT_W-1:0];
            end
          end
        end
        StDispense: begin
          led_q <= sel_onehot(sel_q);
          if (disp_cnt_q == '0) begin
            dispense_q <= 1'b0;
            if (credit_q != '0) begin
              state_q        <= StRefund;
              refund_valid_q <= 1'b1;
              refund_amt_q   <= credit_q;
              led_q          <= 4'hf;
            end else begin
              state_q <= StIdle;
              led_q   <= sel_onehot(bus.sw);
            end
          end else begin
            disp_cnt_q <= disp_cnt_q - 1'b1;
          end
        end
        StRefund: begin
          state_q      <= StIdle;
          credit_q     <= '0;
          refund_amt_q <= '0;
          led_q        <= sel_onehot(bus.sw);
        end
      endcase
    end
  end

  assign bus.led          = led_q;
  assign bus.dispense     = dispense_q;
  assign bus.refund_valid = refund_valid_q;
  assign bus.refund_amt   = refund_amt_q;
  assign bus.coin_reject  = coin_reject_q;
  assign bus.short_credit = short_credit_q;

endmodule

// File: tb/tb_vend_ctrl_fsm.sv
// Self-checking bench for vend_ctrl_fsm with short debounce/dispense times.
// Output pulses are checked against a queue of expected events.
module tb_vend_ctrl_fsm;
  import vend_pkg::*;

  localparam int EvShort  = 1;
  localparam int EvReject = 2;
  localparam int EvDisp   = 3;
  localparam int EvRefund = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  vend_ctrl_fsm_if bus();

  vend_ctrl_fsm #(
    .DEBOUNCE_CYCLES(4),
    .DISPENSE_CYCLES(8),
    .PRICE0         (2),
    .PRICE1         (3),
    .PRICE2         (4),
    .PRICE3         (5),
    .MAX_CREDIT     (15)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int         errors = 0;
  int         checks = 0;
  int         exp_q[$];
  logic [3:0] exp_disp_led = 4'b0001;
  int         disp_len = 0;
  logic       disp_prev = 1'b0;

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic expect_ev(input int kind, input int data);
    exp_q.push_back(kind * 256 + data);
  endtask

  task automatic sb_obs(input int got);
    int exp;
    if (exp_q.size() == 0) begin
      check_eq("sb_unexpected_event", got, 0);
    end else begin
      exp = exp_q.pop_front();
      check_eq("sb_event", got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input int idx);
    bus.btn[idx] = 1'b1;
    tick(10);
    bus.btn[idx] = 1'b0;
    tick(10);
  endtask

  // Output monitor: dispense length/LED, refund, reject and short pulses.
  always @(negedge clk) begin
    if (!rst_n) begin
      disp_prev = 1'b0;
      disp_len  = 0;
    end else begin
      if (bus.dispense) begin
        disp_len++;
        check_eq("disp_led", int'(bus.led), int'(exp_disp_led));
      end else if (disp_prev) begin
        sb_obs(EvDisp * 256 + disp_len);
        disp_len = 0;
      end
      disp_prev = bus.dispense;
      if (bus.refund_valid) begin
        sb_obs(EvRefund * 256 + int'(bus.refund_amt));
        check_eq("refund_led", int'(bus.led), 15);
      end
      if (bus.coin_reject) sb_obs(EvReject * 256);
      if (bus.short_credit) sb_obs(EvShort * 256);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.sw  = 2'b00;
    bus.btn = 4'b0000;
    tick(3);
    check_eq("rst_led", int'(bus.led), 0);
    check_eq("rst_dispense", int'(bus.dispense), 0);
    check_eq("rst_refund_valid", int'(bus.refund_valid), 0);
    check_eq("rst_refund_amt", int'(bus.refund_amt), 0);
    check_eq("rst_coin_reject", int'(bus.coin_reject), 0);
    check_eq("rst_short_credit", int'(bus.short_credit), 0);
    rst_n = 1'b1;
    tick(2);
    check_eq("idle_led_sw00", int'(bus.led), 1);

    // Bounce rejection, then a clean coin1 press.
    bus.sw = 2'b10;
    tick(2);
    check_eq("idle_led_sw10", int'(bus.led), 4);
    bus.btn[0] = 1'b1; tick(2);
    bus.btn[0] = 1'b0; tick(2);
    bus.btn[0] = 1'b1; tick(2);
    bus.btn[0] = 1'b0; tick(15);
    check_eq("bounce_ignored", int'(bus.led), 4);
    press(BTN_COIN1);
    check_eq("coin1_credit", int'(bus.led), 1);
    expect_ev(EvRefund, 1);
    press(BTN_CANCEL);
    tick(2);
    check_eq("idle_after_cancel", int'(bus.led), 4);
    check_eq("drain_1", exp_q.size(), 0);

    // Exact purchase.
    press(BTN_COIN2);
    check_eq("credit_2", int'(bus.led), 2);
    press(BTN_COIN1);
    check_eq("credit_3", int'(bus.led), 3);
    bus.sw = 2'b01;
    exp_disp_led = 4'b0010;
    expect_ev(EvDisp, 8);
    press(BTN_VEND);
    tick(3);
    check_eq("idle_after_exact", int'(bus.led), 2);
    check_eq("drain_2", exp_q.size(), 0);

    // Purchase with change.
    bus.sw = 2'b00;
    press(BTN_COIN2); press(BTN_COIN2); press(BTN_COIN2); press(BTN_COIN1);
    check_eq("credit_7", int'(bus.led), 7);
    bus.sw = 2'b11;
    exp_disp_led = 4'b1000;
    expect_ev(EvDisp, 8);
    expect_ev(EvRefund, 2);
    press(BTN_VEND);
    tick(3);
    check_eq("idle_after_change", int'(bus.led), 8);
    check_eq("drain_3", exp_q.size(), 0);

    // Short credit and overflow.
    press(BTN_COIN2);
    bus.sw = 2'b10;
    expect_ev(EvShort, 0);
    press(BTN_VEND);
    check_eq("short_keeps_credit", int'(bus.led), 2);
    for (int i = 0; i < 6; i++) press(BTN_COIN2);
    check_eq("credit_14", int'(bus.led), 14);
    expect_ev(EvReject, 0);
    press(BTN_COIN2);
    check_eq("reject_keeps_credit", int'(bus.led), 14);
    press(BTN_COIN1);
    check_eq("credit_15", int'(bus.led), 15);
    expect_ev(EvRefund, 15);
    press(BTN_CANCEL);
    tick(2);
    check_eq("idle_after_refund15", int'(bus.led), 4);
    check_eq("drain_4", exp_q.size(), 0);

    // Cancel and vend in the same cycle: cancel wins.
    press(BTN_COIN2); press(BTN_COIN2); press(BTN_COIN1);
    check_eq("credit_5", int'(bus.led), 5);
    expect_ev(EvRefund, 5);
    bus.btn[BTN_VEND]   = 1'b1;
    bus.btn[BTN_CANCEL] = 1'b1;
    tick(10);
    bus.btn = 4'b0000;
    tick(10);
    check_eq("idle_after_simul", int'(bus.led), 4);
    check_eq("drain_5", exp_q.size(), 0);

    // Coin press during dispense is ignored.
    bus.sw = 2'b00;
    press(BTN_COIN2); press(BTN_COIN2); press(BTN_COIN1);
    exp_disp_led = 4'b0001;
    expect_ev(EvDisp, 8);
    expect_ev(EvRefund, 3);
    bus.btn[BTN_VEND] = 1'b1;
    tick(3);
    bus.btn[BTN_COIN1] = 1'b1;
    tick(10);
    bus.btn[BTN_VEND] = 1'b0;
    tick(3);
    bus.btn[BTN_COIN1] = 1'b0;
    tick(15);
    check_eq("idle_after_disp_coin", int'(bus.led), 1);
    check_eq("drain_6", exp_q.size(), 0);

    // Asynchronous reset mid-dispense.
    press(BTN_COIN2); press(BTN_COIN2);
    check_eq("credit_4", int'(bus.led), 4);
    bus.btn[BTN_VEND] = 1'b1;
    for (int i = 0; i < 30; i++) begin
      if (bus.dispense) break;
      tick(1);
    end
    check_eq("disp_started", int'(bus.dispense), 1);
    tick(2);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_dispense", int'(bus.dispense), 0);
    check_eq("async_rst_led", int'(bus.led), 0);
    check_eq("async_rst_refund", int'(bus.refund_valid), 0);
    bus.btn = 4'b0000;
    tick(3);
    rst_n = 1'b1;
    tick(2);
    check_eq("idle_after_rst", int'(bus.led), 1);
    press(BTN_COIN1);
    check_eq("credit_cleared", int'(bus.led), 1);
    expect_ev(EvRefund, 1);
    press(BTN_CANCEL);
    tick(3);
    check_eq("drain_7", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vend_ctrl_fsm.md
Name: vend_ctrl_fsm

Overview:
- Vending-machine controller for the Arty Z7 board.
- Debounces the four push-buttons into coin, vend and cancel events, and accumulates credit.
- Uses the 2-bit switch bank to select one of four products, sequences dispense and refund, and drives the 4 user LEDs.
- Sits between the board I/O pins and the LED/indicator outputs; it is the sequencing layer over the switch-to-one-hot LED decode.

Parameters:
- DEBOUNCE_CYCLES, 1250000, stable-input cycles before a button level is accepted (10 ms at 125 MHz).
- DISPENSE_CYCLES, 62500000, cycles the dispense output is held (0.5 s).
- PRICE0, 2, price of product 0 in credit units.
- PRICE1, 3, price of product 1.
- PRICE2, 4, price of product 2.
- PRICE3, 5, price of product 3.
- MAX_CREDIT, 15, credit ceiling; must be <= 15.

Ports:
- clk  input  1  125 MHz board clock
- rst_n  input  1  asynchronous active-low reset
- sw  input  2  product select
- btn  input  4  raw buttons: [0] coin 1 unit, [1] coin 2 units, [2] vend, [3] cancel
- led  output  4  status display
- dispense  output  1  high while product is being dispensed
- refund_valid  output  1  one-cycle pulse; refund_amt is valid
- refund_amt  output  4  credit units returned
- coin_reject  output  1  one-cycle pulse; coin refused
- short_credit  output  1  one-cycle pulse; vend refused, credit below price

Behaviour:
- Reset and clock/reset rules:
  - Interface: one clock, clk; reset is asynchronous and active-low, rst_n.
  - While reset is asserted, all outputs are 0, credit is 0, the FSM is in IDLE, and debounce counters are cleared.
  - Reset mid-dispense aborts with no refund pulse.
- Input conditioning:
  - Each btn bit passes through a 2-flop synchroniser, then a debounce counter.
  - The debounced level changes only after DEBOUNCE_CYCLES consecutive cycles of a differing synchronised level.
  - Rising-edge detect on the debounced level produces a one-cycle event.
- Event priority in the same cycle: cancel > vend > coin2 > coin1. Only the highest-priority event is acted on; the others are dropped.
- FSM states: IDLE, COLLECT, DISPENSE, REFUND.
- IDLE:
  - credit = 0.
  - led = one-hot of live sw (00->0001, 01->0010, 10->0100, 11->1000).
  - A coin event adds its value to credit and moves to COLLECT next cycle.
  - Vend gives a short_credit pulse. Cancel is ignored.
- COLLECT:
  - led = credit[3:0].
  - Coin: if credit + value > MAX_CREDIT, coin_reject pulses and credit is unchanged; otherwise credit += value.
  - Vend:
    - Latch sel_q = sw.
    - If credit >= PRICE[sw], then credit -= price and go to DISPENSE.
    - Otherwise short_credit pulses and the state stays COLLECT.
  - Cancel -> REFUND.
- DISPENSE:
  - dispense = 1 and led = one-hot of sel_q.
  - A down-counter loads DISPENSE_CYCLES-1 on entry; dispense is high for exactly DISPENSE_CYCLES cycles.
  - At terminal count: go to REFUND if credit > 0, otherwise IDLE.
  - All button events are ignored (not queued).
- REFUND:
  - Lasts exactly one cycle: refund_valid = 1, refund_amt = credit, led = 1111.
  - Next cycle: credit = 0 and the state is IDLE.
  - Events arriving in this cycle are ignored.
- Arithmetic and timing:
  - Credit arithmetic is 5-bit internally for the overflow compare; the stored value is 4 bits and never wraps.
  - All outputs are registered. Event-to-output latency is 1 cycle after the debounced edge.

Decomposition:
- Shared package vend_pkg:
  - state enum (IDLE, COLLECT, DISPENSE, REFUND)
  - button index constants (BTN_COIN1=0, BTN_COIN2=1, BTN_VEND=2, BTN_CANCEL=3)
  - coin value constants
  - credit width constant (4)
- One sub-module, btn_debounce:
  - synchroniser, debounce counter and rising-edge pulse for one bit, parameterised by DEBOUNCE_CYCLES.
  - Instantiated 4 times.

Test Plan (DEBOUNCE_CYCLES=4, DISPENSE_CYCLES=8):
- Bounce rejection: pulse btn[0] high 2 cycles, low, high 2 cycles -> no credit change. Hold btn[0] high 10 cycles -> credit 1, led=0001, state COLLECT.
- Exact purchase: coin2 + coin1 (credit 3), sw=01, vend -> dispense high for exactly 8 cycles with led=0010, then IDLE, no refund_valid.
- Purchase with change: credit 7, sw=11, vend -> dispense 8 cycles, then refund_valid for 1 cycle with refund_amt=2, then IDLE, led = one-hot(sw).
- Short credit and overflow: credit 2, sw=10, vend -> short_credit pulse, credit stays 2. Raise credit to 14, coin2 -> coin_reject, credit stays 14. Coin1 -> credit 15.
- Cancel and simultaneity: credit 5; cancel and vend debounced in the same cycle -> REFUND with refund_amt=5, no dispense. Coin presses during DISPENSE -> credit unchanged.
- Async reset: assert rst_n low mid-DISPENSE (no clk edge) -> dispense=0 and led=0000 immediately. After release -> IDLE, credit 0.
